ddr3_burst_writer: RTL and testbench
====================================

DDR3_BURST_WRITER -- requirements
Module: ddr3_burst_writer

Interface
REQ-001 Parameter BURST_LEN, default 32: Avalon beats per write burst, power of two, 2..64.
REQ-002 Parameter ADDR_W, default 25: Avalon word-address width.
REQ-003 Parameter BASE_ADDR, default 0: frame buffer start word address.
REQ-004 Parameter FRAME_WORDS, default 1280*720: pixels per frame; integer multiple of BURST_LEN.
REQ-005 Reset rstn, asynchronous, active-low; clock clk.
REQ-006 clk  in  1  DDR3 controller user clock; same clock as FIFO read side.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 frame_start  in  1  single-cycle pulse in clk domain marking a new frame; FIFO has just been cleared.
REQ-009 fifo_usedw  in  8  FIFO read-side fill level.
REQ-010 fifo_empty  in  1  FIFO read-side empty flag.
REQ-011 fifo_data  in  24  show-ahead FIFO head word (RGB888); valid whenever fifo_empty=0.
REQ-012 fifo_rdreq  out  1  FIFO pop acknowledge.
REQ-013 avm_address  out  ADDR_W  burst start word address.
REQ-014 avm_write  out  1  Avalon write request.
REQ-015 avm_writedata  out  32  write data.
REQ-016 avm_burstcount  out  7  burst length.
REQ-017 avm_waitrequest  in  1  slave stall.
REQ-018 frame_done  out  1  one-cycle pulse after the last burst of a frame is accepted.

Function
REQ-019 FSM states: IDLE, BURST. Pixel data passes through combinationally; no data register.
REQ-020 IDLE->BURST when fifo_usedw >= BURST_LEN; avm_address and avm_burstcount are loaded on that edge and held constant until burst end.
REQ-021 In BURST: avm_write = ~fifo_empty; fifo_rdreq = avm_write & ~avm_waitrequest; avm_writedata = {8'h00, fifo_data}.
REQ-022 Beat counter increments on each accepted beat (avm_write & ~avm_waitrequest); BURST->IDLE on acceptance of beat BURST_LEN.
REQ-023 fifo_empty asserted mid-burst: avm_write deasserts, burst pauses, and burst resumes when data returns; burst is never abandoned.
REQ-024 avm_burstcount = BURST_LEN, constant.
REQ-025 At burst end, address += BURST_LEN and frame word count += BURST_LEN; on reaching FRAME_WORDS, address returns to BASE_ADDR, count clears, and frame_done pulses on the following cycle.
REQ-026 frame_start in IDLE: address <= BASE_ADDR and count <= 0 next cycle, with no frame_done.
REQ-027 frame_start during BURST: latched; current burst completes at the old address, then address and count are reset instead of advanced.
REQ-028 frame_start coincident with the frame-wrap burst end: reset wins and frame_done is still pulsed.
REQ-029 Minimum one IDLE cycle between bursts.

Reset
REQ-030 Asynchronous reset values: state IDLE, avm_write 0, fifo_rdreq 0, avm_address BASE_ADDR, beat and frame counters 0, frame_done 0, pending-frame_start flag 0.
REQ-031 Reset applied mid-burst aborts the burst immediately; the downstream controller is reset together with this block.

Configuration
REQ-032 Macro BURST_WR_STATS_EN defined: adds outputs stat_bursts (16 bits, wraps) counting completed bursts and stat_stalls (16 bits, saturating) counting BURST cycles with fifo_empty=1; both clear on reset and on frame_start.
REQ-033 Macro BURST_WR_STATS_EN undefined: these ports and counters do not exist and all other behaviour is identical.

Structure
REQ-034 Shared package ddr3_test_pkg holds the FSM state encoding, the pixel pad constant (8'h00), and the data widths 24 and 32.
REQ-035 Single flat module; no sub-module is required.

Verification
REQ-036 BURST_LEN=4, fifo_usedw=4, waitrequest=0 -> 4 consecutive writes at address 0, burstcount 4, then address 4.
REQ-037 waitrequest high on beats 2-3 for 2 cycles -> data held stable, no rdreq while stalled, 4 beats total.
REQ-038 fifo_empty for 3 cycles mid-burst -> avm_write low for 3 cycles, then burst resumes; no extra or lost beats.
REQ-039 FRAME_WORDS=8, BURST_LEN=4, 2 bursts -> frame_done pulses once, next burst at BASE_ADDR.
REQ-040 frame_start on beat 2 of a burst at address 4 -> burst finishes at address 4, next burst at BASE_ADDR.
REQ-041 rstn low mid-burst -> avm_write and fifo_rdreq are 0 immediately, and avm_address = BASE_ADDR.

Source files
------------

// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 frame-buffer writer: FSM encoding,
// pixel/bus widths and the pad byte that widens RGB888 to the Avalon bus.
package ddr3_test_pkg;

   localparam int PIX_W      = 24;
   localparam int AVM_DATA_W = 32;

   localparam logic [AVM_DATA_W-PIX_W-1:0] PIX_PAD = 8'h00;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/ddr3_burst_writer.sv
// Drains a show-ahead pixel FIFO into DDR3 as fixed-length Avalon write bursts.
// Optional statistics counters are enabled with `define BURST_WR_STATS_EN.
module ddr3_burst_writer
   import ddr3_test_pkg::*;
#(
   parameter int          BURST_LEN   = 32,
   parameter int          ADDR_W      = 25,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned FRAME_WORDS = 1280*720
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  frame_start,
   input  logic [7:0]            fifo_usedw,
   input  logic                  fifo_empty,
   input  logic [PIX_W-1:0]      fifo_data,
   output logic                  fifo_rdreq,
   output logic [ADDR_W-1:0]     avm_address,
   output logic                  avm_write,
   output logic [AVM_DATA_W-1:0] avm_writedata,
   output logic [6:0]            avm_burstcount,
   input  logic                  avm_waitrequest,
   output logic                  frame_done
`ifdef BURST_WR_STATS_EN
   ,
   output logic [15:0]           stat_bursts,
   output logic [15:0]           stat_stalls
`endif
);

   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam int FCNT_W = $clog2(FRAME_WORDS + 1);

   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
   localparam logic [8:0]        USEDW_MIN  = 9'(BURST_LEN);
   localparam logic [FCNT_W-1:0] FCNT_STEP  = FCNT_W'(BURST_LEN);
   localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FRAME_WORDS - BURST_LEN);
   localparam logic [ADDR_W-1:0] ADDR_BASE  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);

   state_t              state, state_n;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [FCNT_W-1:0]   frame_cnt;
   logic                start_pend;
   logic                burst_end;
   logic                wrap;
   logic                restart;

   assign avm_burstcount = 7'(BURST_LEN);
   assign avm_writedata  = {PIX_PAD, fifo_data};
   assign wrap           = (frame_cnt == FCNT_LAST);
   assign restart        = start_pend | frame_start;

   // A frame_start seen in IDLE holds off the next burst for one cycle so the
   // address reset never collides with the burst-start edge.
   always_comb begin
      state_n    = state;
      avm_write  = 1'b0;
      fifo_rdreq = 1'b0;
      burst_end  = 1'b0;
      case (state)
         IDLE: begin
            if (!frame_start && ({1'b0, fifo_usedw} >= USEDW_MIN))
               state_n = BURST;
         end
         BURST: begin
            avm_write  = ~fifo_empty;
            fifo_rdreq = avm_write & ~avm_waitrequest;
            burst_end  = fifo_rdreq && (beat_cnt == LAST_BEAT);
            if (burst_end)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_n;
   end

   // A restart request (pending or arriving on the last beat) overrides the
   // normal address advance; frame_done still reports a natural frame wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt    <= '0;
         frame_cnt   <= '0;
         avm_address <= ADDR_BASE;
         frame_done  <= 1'b0;
         start_pend  <= 1'b0;
      end else begin
         frame_done <= burst_end & wrap;
         if (state == BURST) begin
            if (fifo_rdreq)
               beat_cnt <= burst_end ? '0 : beat_cnt + BEAT_W'(1);
            if (burst_end) begin
               start_pend <= 1'b0;
               if (restart || wrap) begin
                  avm_address <= ADDR_BASE;
                  frame_cnt   <= '0;
               end else begin
                  avm_address <= avm_address + ADDR_STEP;
                  frame_cnt   <= frame_cnt + FCNT_STEP;
               end
            end else if (frame_start) begin
               start_pend <= 1'b1;
            end
         end else if (frame_start) begin
            avm_address <= ADDR_BASE;
            frame_cnt   <= '0;
         end
      end
   end

`ifdef BURST_WR_STATS_EN
   // Burst count wraps; stall count saturates so long starvation stays visible.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_bursts <= '0;
         stat_stalls <= '0;
      end else if (frame_start) begin
         stat_bursts <= '0;
         stat_stalls <= '0;
      end else begin
         if (burst_end)
            stat_bursts <= stat_bursts + 16'd1;
         if ((state == BURST) && fifo_empty && (stat_stalls != 16'hFFFF))
            stat_stalls <= stat_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr3_burst_writer.sv
// Scoreboard bench for ddr3_burst_writer (BURST_LEN=4, FRAME_WORDS=12, BASE_ADDR=0)
// with a behavioural show-ahead FIFO feeding the DUT.
module tb_ddr3_burst_writer;

   localparam int BL = 4;
   localparam int AW = 25;
   localparam int FW = 12;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          frame_start = 1'b0;
   logic [7:0]    fifo_usedw = 8'd0;
   logic          fifo_empty = 1'b1;
   logic [23:0]   fifo_data = 24'd0;
   logic          fifo_rdreq;
   logic [AW-1:0] avm_address;
   logic          avm_write;
   logic [31:0]   avm_writedata;
   logic [6:0]    avm_burstcount;
   logic          avm_waitrequest = 1'b0;
   logic          frame_done;

   ddr3_burst_writer #(
      .BURST_LEN   (BL),
      .ADDR_W      (AW),
      .BASE_ADDR   (0),
      .FRAME_WORDS (FW)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .frame_start     (frame_start),
      .fifo_usedw      (fifo_usedw),
      .fifo_empty      (fifo_empty),
      .fifo_data       (fifo_data),
      .fifo_rdreq      (fifo_rdreq),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_burstcount  (avm_burstcount),
      .avm_waitrequest (avm_waitrequest),
      .frame_done      (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } beat_t;

   beat_t       expq[$];
   logic [23:0] pixq[$];
   int          tests = 0;
   int          fails = 0;
   int          accepted = 0;
   int          done_cnt = 0;
   logic        starve = 1'b0;
   logic        pop_pending = 1'b0;
   logic        done_prev = 1'b0;
   logic [23:0] pix_next = 24'hA50001;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue one burst of fresh pixels and the writes they must produce.
   task automatic applyStimulus(input logic [AW-1:0] addr);
      for (int i = 0; i < BL; i++) begin
         pixq.push_back(pix_next);
         expq.push_back({addr, 8'h00, pix_next});
         pix_next = pix_next + 24'h000101;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitBeats(input int target, input string name);
      int n = 0;
      while (accepted < target && n < 50) begin
         tick(1);
         n++;
      end
      checkOutput(name, 32'(accepted), 32'(target));
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (expq.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      checkOutput({name, "_drain"}, 32'(expq.size()), 32'd0);
      checkOutput({name, "_fifo_left"}, 32'(pixq.size()), 32'd0);
      tick(3);
   endtask

   // Show-ahead FIFO model: pops on the edge following a sampled rdreq.
   always begin : fifo_model
      int sz;
      @(posedge clk);
      if (pop_pending && pixq.size() > 0)
         void'(pixq.pop_front());
      #2;
      sz         = pixq.size();
      fifo_empty = starve || (sz == 0);
      fifo_usedw = starve ? 8'd0 : ((sz > 255) ? 8'd255 : 8'(sz));
      fifo_data  = (sz > 0) ? pixq[0] : 24'd0;
   end

   // Monitor: every write cycle is checked against the scoreboard head.
   always @(negedge clk) begin
      if (rstn) begin
         if (starve)
            checkOutput("starve_write_low", 32'(avm_write), 32'd0);
         if (avm_write) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write",
                        avm_address, avm_writedata);
            end else begin
               checkOutput("beat_addr", 32'(avm_address), 32'(expq[0].addr));
               checkOutput("beat_data", avm_writedata, expq[0].data);
               checkOutput("burstcount", 32'(avm_burstcount), 32'd4);
               if (!avm_waitrequest) begin
                  checkOutput("rdreq_on_accept", 32'(fifo_rdreq), 32'd1);
                  void'(expq.pop_front());
                  accepted++;
               end else begin
                  checkOutput("rdreq_while_stalled", 32'(fifo_rdreq), 32'd0);
               end
            end
         end
         if (frame_done) begin
            done_cnt++;
            checkOutput("frame_done_width", 32'(done_prev), 32'd0);
         end
         done_prev = frame_done;
      end
      pop_pending = fifo_rdreq;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      tick(3);
      checkOutput("reset_write", 32'(avm_write), 32'd0);
      checkOutput("reset_rdreq", 32'(fifo_rdreq), 32'd0);
      checkOutput("reset_addr", 32'(avm_address), 32'd0);
      checkOutput("reset_done", 32'(frame_done), 32'd0);
      rstn = 1'b1;

      // Plain burst at 0, address then advances to 4.
      applyStimulus(0);
      waitDrain("t1");
      checkOutput("t1_next_addr", 32'(avm_address), 32'd4);

      // Slave stall for two cycles on the second beat.
      base = accepted;
      applyStimulus(4);
      waitBeats(base + 1, "t2_first_beat");
      avm_waitrequest = 1'b1;
      tick(2);
      avm_waitrequest = 1'b0;
      waitDrain("t2");
      checkOutput("t2_next_addr", 32'(avm_address), 32'd8);

      // FIFO starves for three cycles mid-burst; this burst also closes the frame.
      base = accepted;
      applyStimulus(8);
      waitBeats(base + 1, "t3_first_beat");
      starve = 1'b1;
      tick(3);
      starve = 1'b0;
      waitDrain("t3");
      checkOutput("t3_frame_done", 32'(done_cnt), 32'd1);
      checkOutput("t3_wrap_addr", 32'(avm_address), 32'd0);

      // frame_start during the burst at 4: it finishes there, then restarts at 0.
      base = accepted;
      applyStimulus(0);
      applyStimulus(4);
      waitBeats(base + 5, "t4_beat");
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      waitDrain("t4");
      checkOutput("t4_restart_addr", 32'(avm_address), 32'd0);
      checkOutput("t4_no_frame_done", 32'(done_cnt), 32'd1);
      applyStimulus(0);
      waitDrain("t4b");
      checkOutput("t4b_next_addr", 32'(avm_address), 32'd4);

      // frame_start during the frame-closing burst: restart and frame_done both.
      base = accepted;
      applyStimulus(4);
      applyStimulus(8);
      waitBeats(base + 5, "t5_beat");
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      waitDrain("t5");
      checkOutput("t5_frame_done", 32'(done_cnt), 32'd2);
      checkOutput("t5_addr", 32'(avm_address), 32'd0);

      // frame_start while idle resets address and frame count silently.
      applyStimulus(0);
      waitDrain("t6a");
      checkOutput("t6_addr_before", 32'(avm_address), 32'd4);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(2);
      checkOutput("t6_idle_restart_addr", 32'(avm_address), 32'd0);
      checkOutput("t6_no_frame_done", 32'(done_cnt), 32'd2);
      applyStimulus(0);
      applyStimulus(4);
      applyStimulus(8);
      waitDrain("t6b");
      checkOutput("t6_full_frame_done", 32'(done_cnt), 32'd3);
      checkOutput("t6_wrap_addr", 32'(avm_address), 32'd0);

      // Reset in the middle of a burst at 4 aborts it at once.
      applyStimulus(0);
      waitDrain("t7a");
      base = accepted;
      applyStimulus(4);
      waitBeats(base + 1, "t7_first_beat");
      rstn = 1'b0;
      #1;
      checkOutput("t7_reset_write", 32'(avm_write), 32'd0);
      checkOutput("t7_reset_rdreq", 32'(fifo_rdreq), 32'd0);
      checkOutput("t7_reset_addr", 32'(avm_address), 32'd0);
      expq.delete();
      pixq.delete();
      tick(2);
      rstn = 1'b1;
      tick(3);
      checkOutput("t7_post_reset_write", 32'(avm_write), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
